// File: rtl/fwd_operand_stage.sv
// fwd_operand_stage
// Operand-select pipeline stage. It chooses one of three values: the
// youngest matching in-flight result among NSRC forwarding sources, a
// zero-extended immediate, or the register-file read value. The result
// is registered for the next stage. A load-use hazard is flagged when the
// chosen source has no result yet, and a bubble is inserted in its place.
// Stall holds the stage and flush squashes it. A saturating counter
// records how many operands were supplied by forwarding.
module fwd_operand_stage #(
    parameter int WIDTH      = 16,
    parameter int AW         = 4,
    parameter int NSRC       = 2,
    parameter int IMM_W      = 8,
    parameter int ZERO_GUARD = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [AW-1:0]          in_addr,
    input  logic [WIDTH-1:0]       in_rf_data,
    input  logic [IMM_W-1:0]       in_imm,
    input  logic                   in_imm_sel,
    input  logic [NSRC-1:0]        src_wen,
    input  logic [NSRC*AW-1:0]     src_addr,
    input  logic [NSRC*WIDTH-1:0]  src_data,
    input  logic [NSRC-1:0]        src_ready,
    output logic                   hazard,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [NSRC-1:0]        out_fwd_hit,
    output logic [CNT_W-1:0]       fwd_count
);

    logic              addr_guarded;
    logic [NSRC-1:0]   match;
    logic [NSRC-1:0]   win_onehot;
    logic              win_any;
    logic              win_ready;
    logic [WIDTH-1:0]  win_data;
    logic [WIDTH-1:0]  sel_data;
    logic [NSRC-1:0]   sel_hit;
    logic              fwd_used;
    logic              normal_update;

    // Register 0 is hardwired, so its writes must not be forwarded.
    always_comb begin
        addr_guarded = (ZERO_GUARD != 0) && (in_addr == '0);
    end

    // Compare each source's destination address with the requested register.
    always_comb begin
        match = '0;
        for (int i = 0; i < NSRC; i++) begin
            match[i] = src_wen[i] && (src_addr[i*AW +: AW] == in_addr) && !addr_guarded;
        end
    end

    // Find the youngest matching source. The loop scans from the oldest
    // index to the youngest, so the lowest index is written last and wins.
    // If no source matches, the register file provides the value.
    always_comb begin
        win_onehot = '0;
        win_any    = 1'b0;
        win_ready  = 1'b1;
        win_data   = in_rf_data;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_any       = 1'b1;
                win_ready     = src_ready[i];
                win_data      = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // When the immediate is selected, forwarding is bypassed completely.
    // The immediate is zero-extended and no hit is reported.
    always_comb begin
        sel_data = in_imm_sel ? WIDTH'(in_imm) : win_data;
        sel_hit  = in_imm_sel ? '0 : win_onehot;
        fwd_used = in_valid && !in_imm_sel && win_any;
    end

    // The hazard flag is purely combinational and stays visible while the
    // stage is stalled. A matching source that is not ready cannot be
    // skipped in favour of an older source that is ready.
    always_comb begin
        hazard        = in_valid && !in_imm_sel && win_any && !win_ready;
        normal_update = !flush && !stall && !hazard;
    end

    // Pipeline register. Priority order: reset, flush, stall, hazard
    // bubble, then a normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_fwd_hit <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_fwd_hit <= '0;
        end else if (stall) begin
            out_valid   <= out_valid;
            out_data    <= out_data;
            out_fwd_hit <= out_fwd_hit;
        end else if (hazard) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_fwd_hit <= '0;
        end else begin
            out_valid   <= in_valid;
            out_data    <= in_valid ? sel_data : '0;
            out_fwd_hit <= in_valid ? sel_hit : '0;
        end
    end

    // Performance counter for forwarded operands that are accepted. It
    // stops at all-ones, ignores flush and stall, and only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_count <= '0;
        end else if (normal_update && fwd_used && (fwd_count != '1)) begin
            fwd_count <= fwd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Testbench for fwd_operand_stage.
// It instantiates two copies of the DUT on shared inputs: one with the
// default 16-bit counter and one with a 2-bit counter so that saturation
// can be observed. A behavioural reference model, working from the
// selection rules, predicts the outputs of both copies.
module tb_fwd_operand_stage;

    localparam int WIDTH = 16;
    localparam int AW    = 4;
    localparam int NSRC  = 2;
    localparam int IMM_W = 8;
    localparam int CNT_W = 16;
    localparam int SCNT_W = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic [AW-1:0]         in_addr;
    logic [WIDTH-1:0]      in_rf_data;
    logic [IMM_W-1:0]      in_imm;
    logic                  in_imm_sel;
    logic [NSRC-1:0]       src_wen;
    logic [NSRC*AW-1:0]    src_addr;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_ready;

    logic                  hazard;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [NSRC-1:0]       out_fwd_hit;
    logic [CNT_W-1:0]      fwd_count;

    logic                  s_hazard;
    logic                  s_out_valid;
    logic [WIDTH-1:0]      s_out_data;
    logic [NSRC-1:0]       s_out_fwd_hit;
    logic [SCNT_W-1:0]     s_fwd_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic                  exp_valid;
    logic [WIDTH-1:0]      exp_data;
    logic [NSRC-1:0]       exp_hit;
    int                    exp_count;
    int                    exp_scount;

    fwd_operand_stage #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC), .IMM_W(IMM_W),
                        .ZERO_GUARD(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_addr(in_addr), .in_rf_data(in_rf_data),
        .in_imm(in_imm), .in_imm_sel(in_imm_sel),
        .src_wen(src_wen), .src_addr(src_addr), .src_data(src_data),
        .src_ready(src_ready),
        .hazard(hazard), .out_valid(out_valid), .out_data(out_data),
        .out_fwd_hit(out_fwd_hit), .fwd_count(fwd_count)
    );

    fwd_operand_stage #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC), .IMM_W(IMM_W),
                        .ZERO_GUARD(1), .CNT_W(SCNT_W)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_addr(in_addr), .in_rf_data(in_rf_data),
        .in_imm(in_imm), .in_imm_sel(in_imm_sel),
        .src_wen(src_wen), .src_addr(src_addr), .src_data(src_data),
        .src_ready(src_ready),
        .hazard(s_hazard), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_fwd_hit(s_out_fwd_hit), .fwd_count(s_fwd_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic fl,
                                 input logic v, input logic [AW-1:0] a,
                                 input logic [WIDTH-1:0] rf, input logic [IMM_W-1:0] imm,
                                 input logic isel, input logic [NSRC-1:0] wen,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                 input logic [NSRC-1:0] rdy);
        rst        = r;
        stall      = st;
        flush      = fl;
        in_valid   = v;
        in_addr    = a;
        in_rf_data = rf;
        in_imm     = imm;
        in_imm_sel = isel;
        src_wen    = wen;
        src_addr   = {a1, a0};
        src_data   = {d1, d0};
        src_ready  = rdy;
    endtask

    // Check the hazard for the current inputs, predict the register
    // update from the rules, clock once, and then compare the outputs.
    task automatic runCycle();
        int                w;
        logic              haz;
        logic [AW-1:0]     sa;
        logic [WIDTH-1:0]  sd;
        #1;
        w = -1;
        for (int i = 0; i < NSRC; i++) begin
            sa = src_addr[i*AW +: AW];
            if (w < 0 && src_wen[i] && sa == in_addr && in_addr != 0) w = i;
        end
        haz = in_valid && !in_imm_sel && (w >= 0) && !src_ready[w];
        checkOutput("hazard", 32'(hazard), 32'(haz));
        checkOutput("hazard_small", 32'(s_hazard), 32'(haz));

        if (rst) begin
            exp_valid = 0; exp_data = 0; exp_hit = 0; exp_count = 0; exp_scount = 0;
        end else if (flush) begin
            exp_valid = 0; exp_data = 0; exp_hit = 0;
        end else if (stall) begin
            // everything holds
        end else if (haz) begin
            exp_valid = 0; exp_data = 0; exp_hit = 0;
        end else begin
            exp_valid = in_valid;
            exp_data  = 0;
            exp_hit   = 0;
            if (in_valid) begin
                if (in_imm_sel) exp_data = WIDTH'(in_imm);
                else if (w >= 0) begin
                    sd = src_data[w*WIDTH +: WIDTH];
                    exp_data = sd;
                    exp_hit  = NSRC'(1 << w);
                    if (exp_count < (1 << CNT_W) - 1) exp_count++;
                    if (exp_scount < (1 << SCNT_W) - 1) exp_scount++;
                end else exp_data = in_rf_data;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        checkOutput("out_data", 32'(out_data), 32'(exp_data));
        checkOutput("out_fwd_hit", 32'(out_fwd_hit), 32'(exp_hit));
        checkOutput("fwd_count", 32'(fwd_count), 32'(exp_count));
        checkOutput("small_out_data", 32'(s_out_data), 32'(exp_data));
        checkOutput("small_fwd_count", 32'(s_fwd_count), 32'(exp_scount));
    endtask

    initial begin
        logic [31:0] sat_expect [5];
        sat_expect[0] = 1; sat_expect[1] = 2; sat_expect[2] = 3;
        sat_expect[3] = 3; sat_expect[4] = 3;
        exp_valid = 0; exp_data = 0; exp_hit = 0; exp_count = 0; exp_scount = 0;

        // Reset for two cycles while the other inputs are arbitrary.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, $urandom_range(0,1), $urandom_range(0,1), 1, AW'($urandom),
                          WIDTH'($urandom), IMM_W'($urandom), $urandom_range(0,1),
                          NSRC'($urandom), AW'($urandom), AW'($urandom),
                          WIDTH'($urandom), WIDTH'($urandom), NSRC'($urandom));
            runCycle();
        end
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", 32'(out_data), 32'h0000);
        checkOutput("reset_hit", 32'(out_fwd_hit), 32'd0);
        checkOutput("reset_count", 32'(fwd_count), 32'd0);

        // Both sources match; the youngest one must be chosen.
        applyStimulus(0, 0, 0, 1, 4'd3, 16'h1111, 8'h00, 0, 2'b11, 4'd3, 4'd3,
                      16'hAAAA, 16'h5555, 2'b11);
        runCycle();
        checkOutput("prio_data", 32'(out_data), 32'hAAAA);
        checkOutput("prio_hit", 32'(out_fwd_hit), 32'h1);
        checkOutput("prio_count", 32'(fwd_count), 32'd1);

        // The immediate takes priority over a matching source.
        applyStimulus(0, 0, 0, 1, 4'd3, 16'h1111, 8'h7F, 1, 2'b11, 4'd3, 4'd3,
                      16'hAAAA, 16'h5555, 2'b11);
        runCycle();
        checkOutput("imm_data", 32'(out_data), 32'h007F);
        checkOutput("imm_hit", 32'(out_fwd_hit), 32'h0);
        checkOutput("imm_count", 32'(fwd_count), 32'd1);

        // Address 0 is never forwarded.
        applyStimulus(0, 0, 0, 1, 4'd0, 16'h1234, 8'h00, 0, 2'b01, 4'd0, 4'd9,
                      16'hDEAD, 16'h5555, 2'b11);
        runCycle();
        checkOutput("guard_data", 32'(out_data), 32'h1234);

        // Load-use hazard, then the same request once the result is ready.
        applyStimulus(0, 0, 0, 1, 4'd5, 16'h1111, 8'h00, 0, 2'b01, 4'd5, 4'd2,
                      16'hBEEF, 16'h5555, 2'b00);
        #1 checkOutput("loaduse_hazard", 32'(hazard), 32'd1);
        runCycle();
        checkOutput("loaduse_bubble", 32'(out_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 4'd5, 16'h1111, 8'h00, 0, 2'b01, 4'd5, 4'd2,
                      16'hBEEF, 16'h5555, 2'b01);
        runCycle();
        checkOutput("loaduse_data", 32'(out_data), 32'hBEEF);

        // The younger source is not ready and the older one is; a hazard is still raised.
        applyStimulus(0, 0, 0, 1, 4'd6, 16'h1111, 8'h00, 0, 2'b11, 4'd6, 4'd6,
                      16'h0101, 16'h0202, 2'b10);
        #1 checkOutput("prio_not_ready_hazard", 32'(hazard), 32'd1);
        runCycle();

        // Load a known value, then stall for three cycles with changing inputs.
        applyStimulus(0, 0, 0, 1, 4'd7, 16'h1111, 8'h00, 0, 2'b10, 4'd1, 4'd7,
                      16'h0101, 16'h1357, 2'b11);
        runCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 1, AW'($urandom), WIDTH'($urandom), IMM_W'($urandom),
                          $urandom_range(0,1), NSRC'($urandom), AW'($urandom), AW'($urandom),
                          WIDTH'($urandom), WIDTH'($urandom), NSRC'($urandom));
            runCycle();
            checkOutput("stall_data", 32'(out_data), 32'h1357);
            checkOutput("stall_hit", 32'(out_fwd_hit), 32'h2);
        end

        // When stall and flush are asserted together, flush wins.
        applyStimulus(0, 1, 1, 1, 4'd7, 16'h1111, 8'h00, 0, 2'b10, 4'd1, 4'd7,
                      16'h0101, 16'h1357, 2'b11);
        runCycle();
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_data", 32'(out_data), 32'h0000);

        // The 2-bit counter saturates at 3.
        applyStimulus(1, 0, 0, 0, 4'd0, 16'h0, 8'h00, 0, 2'b00, 4'd0, 4'd0,
                      16'h0, 16'h0, 2'b11);
        runCycle();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 1, 4'd4, 16'h1111, 8'h00, 0, 2'b01, 4'd4, 4'd0,
                          WIDTH'(16'h4000 + k), 16'h0, 2'b11);
            runCycle();
            checkOutput("sat_count", 32'(s_fwd_count), sat_expect[k]);
        end

        // Random traffic, checked against the model.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom % 50) == 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
                          ($urandom % 4) != 0, AW'($urandom % 4), WIDTH'($urandom),
                          IMM_W'($urandom), ($urandom % 5) == 0, NSRC'($urandom),
                          AW'($urandom % 4), AW'($urandom % 4),
                          WIDTH'($urandom), WIDTH'($urandom),
                          {($urandom % 4) != 0, ($urandom % 4) != 0});
            runCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_operand_stage.md
Name: fwd_operand_stage

Overview:
Parametrised operand-select pipeline stage for the 16-bit core: generalises the separate immediate, bypass and flush selects into one registered block. It picks the newest in-flight result for a source register out of NSRC forwarding sources, or a zero-extended immediate, and registers it into the next stage. It detects load-use hazards, inserts a bubble for them, honours stall and flush, and keeps a saturating forward counter for performance analysis.

Parameters:
WIDTH, 16, datapath width in bits
AW, 4, register-address width
NSRC, 2, number of forwarding sources; index 0 is the youngest
IMM_W, 8, immediate width; zero-extended to WIDTH
ZERO_GUARD, 1, when 1 address 0 is never forwarded
CNT_W, 16, forward-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold stage contents
flush  in  1  squash stage to NOP
in_valid  in  1  incoming operand request valid
in_addr  in  AW  source register address
in_rf_data  in  WIDTH  register-file read value
in_imm  in  IMM_W  immediate field
in_imm_sel  in  1  1 = use the immediate, 0 = use the register
src_wen  in  NSRC  source i writes a register
src_addr  in  NSRC*AW  destination address of source i, packed with i*AW as LSB
src_data  in  NSRC*WIDTH  result of source i, packed
src_ready  in  NSRC  result of source i is available (0 = load still in flight)
hazard  out  1  combinational load-use hazard; upstream must hold
out_valid  out  1  registered operand valid
out_data  out  WIDTH  registered operand
out_fwd_hit  out  NSRC  registered one-hot of the source used; 0 if none
fwd_count  out  CNT_W  saturating count of forwarded operands

Behaviour:
- match[i] = src_wen[i] & (src_addr[i] == in_addr) & ~(ZERO_GUARD & in_addr == 0).
- Winner is the lowest-index set match[i]. If no match[i] is set, the operand comes from the register file.
- Selected value:
  - in_imm_sel = 1: zero-extended in_imm. No forwarding, no hazard.
  - otherwise: src_data[winner] if a winner exists, else in_rf_data.
- hazard = in_valid & ~in_imm_sel & winner exists & ~src_ready[winner]. Purely combinational; it is asserted even during stall.
- Register update on each rising edge, in this priority order:
  1. rst: out_valid = 0, out_data = 0, out_fwd_hit = 0, fwd_count = 0.
  2. flush: out_valid = 0, out_data = 0, out_fwd_hit = 0. flush wins over stall and hazard.
  3. stall: all registers hold.
  4. hazard: bubble; out_valid = 0, out_data = 0, out_fwd_hit = 0.
  5. normal: out_valid = in_valid; out_data = selected value and out_fwd_hit = onehot(winner) when in_valid, else both 0.
- fwd_count:
  - increments only on a normal update with in_valid & ~in_imm_sel & winner exists;
  - saturates at all-ones;
  - unaffected by flush or stall; cleared only by rst.
- Latency: 1 cycle from input to out_*.
- Lower-index priority applies even when src_ready[0] = 0 and src_ready[1] = 1: the hazard is raised and the older value is never used.
- Reset mid-stall or mid-hazard gives the rst values on the next edge; nothing is retained.
- When in_valid = 0: no hazard, no count increment, out_data = 0.

Test Plan:
- Reset: assert rst 2 cycles with arbitrary inputs -> out_valid = 0, out_data = 0x0000, out_fwd_hit = 0, fwd_count = 0.
- Priority: in_addr = 3, src_wen = 2'b11, both addresses = 3, src_data0 = 0xAAAA, src_data1 = 0x5555, ready = 11 -> next cycle out_data = 0xAAAA, out_fwd_hit = 01, fwd_count = 1.
- Immediate and guard:
  - in_imm_sel = 1, in_imm = 0x7F, matching source present -> out_data = 0x007F, out_fwd_hit = 0, no count.
  - in_addr = 0 with src_addr0 = 0 -> out_data = in_rf_data.
- Load-use: match on source 0 with src_ready0 = 0 -> hazard = 1, next out_valid = 0. Raise ready -> hazard = 0, next out_data = src_data0.
- Stall/flush:
  - stall = 1 for 3 cycles with changing inputs -> outputs frozen.
  - stall = 1 and flush = 1 together -> out_valid = 0, out_data = 0 next edge.
- Saturation: with CNT_W = 2, drive 5 consecutive forwarded operands -> fwd_count reads 1, 2, 3, 3, 3.
